// File: rtl/dmux8way16_buf.sv
// 1-to-8 demultiplexer of 16-bit words with a one-entry valid/ready buffer per channel.
// Optional broadcast (load all eight channels at once) is enabled by DMUX8WAY16_BUF_BROADCAST_EN.
module dmux8way16_buf #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      in,
    input  logic [2:0]       sel,
    input  logic             in_valid,
`ifdef DMUX8WAY16_BUF_BROADCAST_EN
    input  logic             bcast,
`endif
    output logic             in_ready,
    output logic [15:0]      out0,
    output logic [15:0]      out1,
    output logic [15:0]      out2,
    output logic [15:0]      out3,
    output logic [15:0]      out4,
    output logic [15:0]      out5,
    output logic [15:0]      out6,
    output logic [15:0]      out7,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       valid_q;
    logic [7:0]       valid_d;
    logic [15:0]      data_q [8];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [7:0]       drain;
    logic [7:0]       fill;
    logic             ready_sel;
    logic             accept;
`ifdef DMUX8WAY16_BUF_BROADCAST_EN
    logic             ready_all;
`endif

    always_comb begin
        drain     = valid_q & out_ready;
        ready_sel = !valid_q[sel] || out_ready[sel];
`ifdef DMUX8WAY16_BUF_BROADCAST_EN
        // Broadcast needs every channel to be free by the end of this cycle.
        ready_all = &(~valid_q | out_ready);
        in_ready  = !rst_n || (bcast ? ready_all : ready_sel);
`else
        in_ready  = !rst_n || ready_sel;
`endif
        accept    = rst_n && in_valid && in_ready;
        fill      = 8'h00;
        if (accept) begin
`ifdef DMUX8WAY16_BUF_BROADCAST_EN
            fill = bcast ? 8'hFF : (8'h01 << sel);
`else
            fill = 8'h01 << sel;
`endif
        end
        // A refill wins over a drain on the same channel, so no bubble is created.
        valid_d = (valid_q & ~drain) | fill;
        count_d = count_q + CNT_W'(accept);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 8'h00;
            count_q <= '0;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= 16'h0000;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int k = 0; k < 8; k++) begin
                if (fill[k]) begin
                    data_q[k] <= in;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign count     = count_q;
    assign out0      = data_q[0];
    assign out1      = data_q[1];
    assign out2      = data_q[2];
    assign out3      = data_q[3];
    assign out4      = data_q[4];
    assign out5      = data_q[5];
    assign out6      = data_q[6];
    assign out7      = data_q[7];

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Scoreboard bench for dmux8way16_buf; define DMUX8WAY16_BUF_BROADCAST_EN to also exercise broadcast.
module tb_dmux8way16_buf;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [7:0]       v;
        logic [7:0][15:0] d;
        logic [CW-1:0]    c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   in = 16'h0;
    logic [2:0]    sel = 3'd0;
    logic          in_valid = 1'b0;
    logic          bcast = 1'b0;
    logic          in_ready;
    logic [15:0]   out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready = 8'h00;
    logic [CW-1:0] count;
    logic [7:0][15:0] outs;

    logic [7:0]       m_valid = 8'h00;
    logic [7:0][15:0] m_data  = '0;
    logic [CW-1:0]    m_count = '0;
    exp_t             sb [$];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign outs = {out7, out6, out5, out4, out3, out2, out1, out0};

    dmux8way16_buf #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .sel       (sel),
        .in_valid  (in_valid),
`ifdef DMUX8WAY16_BUF_BROADCAST_EN
        .bcast     (bcast),
`endif
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle: drive, check in_ready against the model, push expected state, compare.
    task automatic step(input logic rst, input logic iv, input logic [2:0] s, input logic [15:0] d,
                        input logic [7:0] ordy, input logic bc);
        logic exp_rdy;
        exp_t e;
        @(negedge clk);
        rst_n = rst; in_valid = iv; sel = s; in = d; out_ready = ordy; bcast = bc;
        #1;
        if (!rst) exp_rdy = 1'b1;
        else if (bc) exp_rdy = (m_valid & ~ordy) == 8'h00;
        else exp_rdy = !(m_valid[s] && !ordy[s]);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (!rst) begin
            m_valid = 8'h00;
            m_data  = '0;
            m_count = '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_valid[k] && ordy[k]) m_valid[k] = 1'b0;
            end
            if (iv && exp_rdy) begin
                for (int k = 0; k < 8; k++) begin
                    if (bc || k == int'(s)) begin
                        m_valid[k] = 1'b1;
                        m_data[k]  = d;
                    end
                end
                m_count = m_count + 1'b1;
            end
        end
        sb.push_back('{v: m_valid, d: m_data, c: m_count});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("out_valid", {24'd0, out_valid}, {24'd0, e.v});
            check("count", {{(32-CW){1'b0}}, count}, {{(32-CW){1'b0}}, e.c});
            for (int k = 0; k < 8; k++) begin
                check($sformatf("out%0d", k), {16'd0, outs[k]}, {16'd0, e.d[k]});
            end
        end
    endtask

    initial begin
        // Reset with stimulus active: nothing may be accepted.
        step(1'b0, 1'b1, 3'd2, 16'hFFFF, 8'hFF, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
        check("rst_valid", {24'd0, out_valid}, 32'h0);

        // First accept has one cycle of latency.
        step(1'b1, 1'b1, 3'd3, 16'hA5A5, 8'h00, 1'b0);
        check("sc1_valid", {24'd0, out_valid}, 32'h08);
        check("sc1_out3", {16'd0, out3}, 32'hA5A5);
        check("sc1_count", {28'd0, count}, 32'd1);

        // Full and stalled channel blocks a second word.
        step(1'b1, 1'b1, 3'd3, 16'h5555, 8'h00, 1'b0);
        check("stall_out3", {16'd0, out3}, 32'hA5A5);
        check("stall_count", {28'd0, count}, 32'd1);

        // Drain and refill in the same cycle.
        step(1'b1, 1'b1, 3'd3, 16'h1234, 8'h08, 1'b0);
        check("refill_out3", {16'd0, out3}, 32'h1234);
        check("refill_valid", {24'd0, out_valid}, 32'h08);
        check("refill_count", {28'd0, count}, 32'd2);

        // Ready on empty channels has no effect; drain channel 3.
        step(1'b1, 1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);

        // Fill all channels with their index, then drain all at once.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 3'(k), 16'(k), 8'h00, 1'b0);
        end
        step(1'b1, 1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);
        check("drain_all_valid", {24'd0, out_valid}, 32'h0);
        check("hold_out6", {16'd0, out6}, 32'h6);

        // Independent drains on other channels while accepting on sel.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 3'(k), 16'h100 + 16'(k), 8'h00, 1'b0);
        step(1'b1, 1'b1, 3'd5, 16'hCAFE, 8'h0B, 1'b0);
        check("indep_valid", {24'd0, out_valid}, 32'h24);

        // Counter wrap: run up to all-ones, then one more accept.
        while (m_count != {CW{1'b1}}) step(1'b1, 1'b1, 3'd0, 16'h0F0F, 8'h01, 1'b0);
        step(1'b1, 1'b1, 3'd0, 16'h7777, 8'h01, 1'b0);
        check("count_wrap", {28'd0, count}, 32'd0);

        // Reset while channels are full discards them.
        step(1'b1, 1'b1, 3'd7, 16'h8888, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'd6, 16'h9999, 8'h00, 1'b0);
        check("rst_mid_valid", {24'd0, out_valid}, 32'h0);
        check("rst_mid_out7", {16'd0, out7}, 32'h0);

        // Random traffic, with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom), 3'($urandom), 16'($urandom),
                 8'($urandom), 1'b0);
        end

`ifdef DMUX8WAY16_BUF_BROADCAST_EN
        step(1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
        step(1'b1, 1'b1, 3'd1, 16'hBEEF, 8'h00, 1'b1);
        check("bc_valid", {24'd0, out_valid}, 32'hFF);
        check("bc_out4", {16'd0, out4}, 32'hBEEF);
        // Channel 5 stays full and not ready, so the broadcast must stall.
        step(1'b1, 1'b1, 3'd1, 16'hD00D, 8'hDF, 1'b1);
        check("bc_stall_out5", {16'd0, out5}, 32'hBEEF);
        check("bc_stall_count", {28'd0, count}, 32'd1);
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1, 3'($urandom), 16'($urandom), 8'($urandom), 1'($urandom));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmux8way16_buf.md
DMUX8WAY16_BUF -- requirements
Module: dmux8way16_buf

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of the accepted-word counter.
REQ-002 The block SHALL have these ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in  input  16  data word to distribute.
- sel  input  3  destination channel index, 0..7.
- in_valid  input  1  in/sel valid this cycle.
- in_ready  output  1  block can accept in this cycle.
- out0..out7  output  16 each  per-channel holding-register contents.
- out_valid  output  8  bit k set means channel k holds a word.
- out_ready  input  8  bit k set means consumer k takes the word this cycle.
- count  output  CNT_W  number of words accepted since reset, wrapping.

Function
REQ-003 Each channel k SHALL be a one-entry buffer with two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-004 in_ready SHALL be combinational: !out_valid[sel] || out_ready[sel].
REQ-005 A word SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-006 On accept, out<sel> SHALL load in, and out_valid[sel] SHALL be 1 from the next cycle (latency 1 cycle).
REQ-007 A channel SHALL drain when out_valid[k] && out_ready[k] at a rising edge.
REQ-008 A drained channel SHALL go EMPTY unless it is refilled in the same cycle.
REQ-009 Simultaneous drain and fill of the same channel SHALL leave it FULL with the new word; no bubble, no loss.
REQ-010 Drains on channels other than sel SHALL proceed independently in the same cycle, with any number of drains per cycle.
REQ-011 out_ready[k] while channel k is EMPTY SHALL have no effect.
REQ-012 outk SHALL hold its last loaded value while EMPTY; its value is don't-care to consumers.
REQ-013 in_valid with in_ready=0 SHALL change no state; the producer holds in and sel stable until accepted.
REQ-014 count SHALL increment by 1 on every accept and wrap from 2^CNT_W-1 to 0.
REQ-015 No output except in_ready SHALL depend combinationally on inputs.

Reset
REQ-016 While rst_n=0 at a rising edge, out_valid SHALL be 8'h00, out0..out7 SHALL be 16'h0000, and count SHALL be 0.
REQ-017 Reset SHALL take priority over a simultaneous accept or drain; words buffered mid-operation are discarded.
REQ-018 in_ready SHALL evaluate to 1 during reset, since all channels are EMPTY, but no accept takes effect while rst_n=0.

Configuration
REQ-019 Macro DMUX8WAY16_BUF_BROADCAST_EN SHALL control the broadcast feature.
REQ-020 With the macro defined, the block SHALL add an input port bcast (1 bit).
REQ-021 With bcast=1, in_ready SHALL be 1 only when every channel is EMPTY or draining this cycle.
REQ-022 A broadcast accept SHALL load in into all eight channels, set out_valid=8'hFF, ignore sel, and increment count by 1.
REQ-023 Without the macro, the bcast port SHALL be absent and behaviour SHALL be exactly REQ-003..REQ-018.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, then in=16'hA5A5, sel=3, in_valid=1 for one cycle -> next cycle out_valid=8'h08, out3=16'hA5A5, count=1.
- Channel 3 FULL, out_ready=0, second word sel=3 -> in_ready=0, out3 unchanged, count unchanged.
- Channel 3 FULL, out_ready[3]=1, in=16'h1234, sel=3 -> accepted; next cycle out_valid[3]=1, out3=16'h1234, count+1.
- Fill channels 0..7 with 16'h0000..16'h0007, then out_ready=8'hFF for one cycle -> out_valid=8'h00; each outk equals k.
- Force count to 2^CNT_W-1, accept one word -> count=0; assert rst_n=0 with channels FULL -> out_valid=0 next cycle.
- With DMUX8WAY16_BUF_BROADCAST_EN defined, all channels EMPTY, bcast=1, in=16'hBEEF -> out_valid=8'hFF, all outk=16'hBEEF; repeat with channel 5 FULL and not ready -> in_ready=0.
